pcs_loopback_test_ctrl: RTL and testbench

Sequencer for the 10G PCS line-loopback self-test, run in the receive clock domain. On start it resets the PCS receiver and waits for block lock with no high BER. It then steps a 6-entry test-pattern selector on the transmit side and compares the looped-back SERDES data against a delayed copy of the transmitted data. It reports pass, or fail with a cause code and a mismatch count, replacing the ad-hoc checks scattered through the loopback benches.

---
 rtl/pcs_loopback_test_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pcs_loopback_test_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_loopback_test_ctrl.sv
// rtl/pcs_loopback_test_ctrl.sv - 10G PCS line-loopback self-test sequencer
// Resets the PCS receiver, waits for lock, runs patterns and compares looped-back data.
module pcs_loopback_test_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_PATTERNS  = 6,
  parameter int RST_CYCLES    = 2,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOOP_LATENCY  = 7,
  parameter int RUN_CYCLES    = 128,
  parameter int CNT_WIDTH     = 7
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] tx_data_ref,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_block_lock,
  input  logic                  rx_high_ber,
  input  logic [6:0]            rx_error_count,
  output logic                  pcs_rx_rst_req,
  output logic [2:0]            pattern_sel,
  output logic                  test_active,
  output logic                  test_done,
  output logic                  test_pass,
  output logic [2:0]            fail_code,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_RESET  = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RUN       = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam int M1 = (LOCK_TIMEOUT > RUN_CYCLES) ? LOCK_TIMEOUT : RUN_CYCLES;
  localparam int M2 = (M1 > SETTLE_CYCLES) ? M1 : SETTLE_CYCLES;
  localparam int M3 = (M2 > RST_CYCLES) ? M2 : RST_CYCLES;
  localparam int M4 = (M3 > LOOP_LATENCY) ? M3 : LOOP_LATENCY;
  localparam int CW = $clog2(M4 + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST    = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] FILL        = CW'(LOOP_LATENCY);
  localparam logic [2:0]    PAT_LAST    = 3'(NUM_PATTERNS - 1);

  state_t                 st;
  logic [CW-1:0]          cnt;
  logic [DATA_WIDTH-1:0]  dly [LOOP_LATENCY];
  logic                   active;
  logic                   cmp_hit;
  logic [CNT_WIDTH-1:0]   mm_next;
  logic                   finish;
  logic [2:0]             code;

  assign state = st;

  // Every way out to DONE is resolved here so the register block has one exit path.
  always_comb begin
    active  = (st == RX_RESET) || (st == WAIT_LOCK) || (st == SETTLE) || (st == RUN);
    cmp_hit = (st == RUN) && (cnt >= FILL) && (dly[LOOP_LATENCY-1] != rx_data);
    mm_next = mismatch_count;
    if (cmp_hit && (mismatch_count != {CNT_WIDTH{1'b1}}))
      mm_next = mismatch_count + CNT_WIDTH'(1);
    finish = 1'b0;
    code   = 3'd0;
    if (abort && active) begin
      finish = 1'b1;
      code   = 3'd6;
    end else begin
      case (st)
        WAIT_LOCK:
          if (!(rx_block_lock && !rx_high_ber) && (cnt == LOCK_LAST)) begin
            finish = 1'b1;
            code   = 3'd1;
          end
        SETTLE:
          if (!rx_block_lock) begin
            finish = 1'b1;
            code   = 3'd3;
          end else if (rx_high_ber) begin
            finish = 1'b1;
            code   = 3'd2;
          end
        RUN:
          if (!rx_block_lock) begin
            finish = 1'b1;
            code   = 3'd3;
          end else if (rx_high_ber) begin
            finish = 1'b1;
            code   = 3'd2;
          end else if (rx_error_count != 7'd0) begin
            finish = 1'b1;
            code   = 3'd5;
          end else if (cnt == RUN_LAST) begin
            finish = 1'b1;
            code   = (mm_next != '0) ? 3'd4 : 3'd0;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      st             <= IDLE;
      cnt            <= '0;
      pcs_rx_rst_req <= 1'b0;
      pattern_sel    <= 3'd0;
      test_active    <= 1'b0;
      test_done      <= 1'b0;
      test_pass      <= 1'b0;
      fail_code      <= 3'd0;
      mismatch_count <= '0;
      for (int i = 0; i < LOOP_LATENCY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= tx_data_ref;
      for (int i = 1; i < LOOP_LATENCY; i++) dly[i] <= dly[i-1];
      if (finish) begin
        st             <= DONE;
        pcs_rx_rst_req <= 1'b0;
        pattern_sel    <= 3'd0;
        test_active    <= 1'b0;
        test_done      <= 1'b1;
        test_pass      <= (code == 3'd0);
        fail_code      <= code;
        mismatch_count <= mm_next;
      end else begin
        case (st)
          IDLE, DONE:
            if (start) begin
              st             <= RX_RESET;
              cnt            <= '0;
              pcs_rx_rst_req <= 1'b1;
              test_active    <= 1'b1;
              test_done      <= 1'b0;
              test_pass      <= 1'b0;
              fail_code      <= 3'd0;
              mismatch_count <= '0;
            end
          RX_RESET:
            if (cnt == RST_LAST) begin
              st             <= WAIT_LOCK;
              cnt            <= '0;
              pcs_rx_rst_req <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          WAIT_LOCK:
            if (rx_block_lock && !rx_high_ber) begin
              st  <= SETTLE;
              cnt <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          SETTLE:
            if (cnt == SETTLE_LAST) begin
              st  <= RUN;
              cnt <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          RUN: begin
            cnt            <= cnt + CW'(1);
            pattern_sel    <= (pattern_sel == PAT_LAST) ? 3'd0 : pattern_sel + 3'd1;
            mismatch_count <= mm_next;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcs_loopback_test_ctrl.sv
// tb/tb_pcs_loopback_test_ctrl.sv - directed bench for pcs_loopback_test_ctrl
// A second instance with a 256-cycle run window covers mismatch-count saturation.
module tb_pcs_loopback_test_ctrl;

  logic        rx_clk;
  logic        rx_rst;
  logic        start;
  logic        abort;
  logic [63:0] tx_data_ref;
  logic [63:0] rx_data;
  logic        rx_block_lock;
  logic        rx_high_ber;
  logic [6:0]  rx_error_count;

  logic       pcs_rx_rst_req, test_active, test_done, test_pass;
  logic [2:0] pattern_sel, fail_code, state;
  logic [6:0] mismatch_count;

  logic       s_rst_req, s_active, s_done, s_pass;
  logic [2:0] s_pattern_sel, s_fail_code, s_state;
  logic [6:0] s_mismatch_count;

  int checks;
  int failures;
  logic [63:0] txh [8];

  pcs_loopback_test_ctrl dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .start(start), .abort(abort),
    .tx_data_ref(tx_data_ref), .rx_data(rx_data),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .rx_error_count(rx_error_count),
    .pcs_rx_rst_req(pcs_rx_rst_req), .pattern_sel(pattern_sel),
    .test_active(test_active), .test_done(test_done), .test_pass(test_pass),
    .fail_code(fail_code), .mismatch_count(mismatch_count), .state(state)
  );

  pcs_loopback_test_ctrl #(.RUN_CYCLES(256)) dut_sat (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .start(start), .abort(abort),
    .tx_data_ref(tx_data_ref), .rx_data(rx_data),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .rx_error_count(rx_error_count),
    .pcs_rx_rst_req(s_rst_req), .pattern_sel(s_pattern_sel),
    .test_active(s_active), .test_done(s_done), .test_pass(s_pass),
    .fail_code(s_fail_code), .mismatch_count(s_mismatch_count), .state(s_state)
  );

  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rx_data is tx_data_ref from seven cycles earlier; callers may flip bits after a step.
  task automatic step();
    @(posedge rx_clk);
    #1;
    for (int k = 7; k > 0; k--) txh[k] = txh[k-1];
    tx_data_ref = {$urandom, $urandom};
    txh[0] = tx_data_ref;
    rx_data = txh[7];
  endtask

  task automatic do_reset();
    rx_rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    rx_block_lock = 1'b0;
    rx_high_ber = 1'b0;
    rx_error_count = 7'd0;
    step();
    step();
    rx_rst = 1'b0;
  endtask

  task automatic start_to_run();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rxreset_state", state, 1);
    chk("rxreset_req_c1", pcs_rx_rst_req, 1);
    step();
    chk("rxreset_req_c2", pcs_rx_rst_req, 1);
    step();
    chk("waitlock_state", state, 2);
    chk("waitlock_req_low", pcs_rx_rst_req, 0);
    step();
    rx_block_lock = 1'b1;
    chk("waitlock_hold", state, 2);
    step();
    chk("settle_state", state, 3);
    repeat (7) step();
    chk("settle_last", state, 3);
    step();
    chk("run_entry", state, 4);
    chk("run_entry_pat", pattern_sel, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < 8; k++) txh[k] = '0;
    tx_data_ref = '0;
    rx_data = '0;
    do_reset();
    rx_rst = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_req", pcs_rx_rst_req, 0);
    chk("rst_pat", pattern_sel, 0);
    chk("rst_active", test_active, 0);
    chk("rst_done", test_done, 0);
    chk("rst_pass", test_pass, 0);
    chk("rst_fail", fail_code, 0);
    chk("rst_mm", mismatch_count, 0);
    rx_rst = 1'b0;
    step();

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_ignored", state, 0);

    // Clean loopback, with a stray start mid-run
    start_to_run();
    for (int i = 0; i < 128; i++) begin
      chk("clean_run_state", state, 4);
      chk("clean_pat_seq", pattern_sel, i % 6);
      chk("clean_active", test_active, 1);
      start = (i == 30);
      step();
    end
    start = 1'b0;
    chk("clean_done_state", state, 5);
    chk("clean_done", test_done, 1);
    chk("clean_pass", test_pass, 1);
    chk("clean_fail", fail_code, 0);
    chk("clean_mm", mismatch_count, 0);
    chk("clean_active_low", test_active, 0);
    chk("clean_pat_zero", pattern_sel, 0);

    // Three single-bit flips
    do_reset();
    start_to_run();
    for (int i = 0; i < 128; i++) begin
      if (i == 20 || i == 50 || i == 90) rx_data[5] = ~rx_data[5];
      step();
    end
    chk("flip_state", state, 5);
    chk("flip_fail", fail_code, 4);
    chk("flip_mm", mismatch_count, 3);
    chk("flip_pass", test_pass, 0);

    // 200 flips on a 256-cycle window saturate the count
    do_reset();
    start_to_run();
    for (int i = 0; i < 256; i++) begin
      if (i >= 10 && i < 210) rx_data[0] = ~rx_data[0];
      step();
    end
    chk("sat_state", s_state, 5);
    chk("sat_mm", s_mismatch_count, 127);
    chk("sat_fail", s_fail_code, 4);
    chk("short_mm", mismatch_count, 118);
    chk("short_fail", fail_code, 4);

    // Lock timeout, then abort ignored in DONE, then restart from DONE
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("to_waitlock", state, 2);
    repeat (1023) step();
    chk("to_last_wait", state, 2);
    step();
    chk("to_state", state, 5);
    chk("to_fail", fail_code, 1);
    chk("to_pass", test_pass, 0);
    chk("to_done", test_done, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done_ignored", fail_code, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_fail_clr", fail_code, 0);
    chk("restart_req", pcs_rx_rst_req, 1);
    chk("restart_done_clr", test_done, 0);

    // Lock lost together with high BER: lock lost wins
    do_reset();
    start_to_run();
    repeat (20) step();
    rx_block_lock = 1'b0;
    rx_high_ber = 1'b1;
    step();
    rx_high_ber = 1'b0;
    chk("locklost_state", state, 5);
    chk("locklost_fail", fail_code, 3);
    chk("locklost_pat", pattern_sel, 0);

    // PCS error count alone
    do_reset();
    start_to_run();
    repeat (40) step();
    rx_error_count = 7'd2;
    step();
    rx_error_count = 7'd0;
    chk("errcnt_state", state, 5);
    chk("errcnt_fail", fail_code, 5);

    // Abort in WAIT_LOCK and in RX_RESET
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_wl_state", state, 5);
    chk("abort_wl_fail", fail_code, 6);
    chk("abort_wl_req", pcs_rx_rst_req, 0);
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_rr_req", pcs_rx_rst_req, 0);
    chk("abort_rr_fail", fail_code, 6);

    // Asynchronous reset mid-run, then a clean pass
    do_reset();
    start_to_run();
    repeat (50) step();
    rx_rst = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_pat", pattern_sel, 0);
    chk("async_active", test_active, 0);
    chk("async_fail", fail_code, 0);
    step();
    rx_rst = 1'b0;
    rx_block_lock = 1'b0;
    step();
    start_to_run();
    repeat (128) step();
    chk("after_rst_pass", test_pass, 1);
    chk("after_rst_mm", mismatch_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
